count_readout: RTL and testbench
================================

# count_readout

Downstream consumer of the frequency-measurement stage. It snapshots the latched `cycle_count` on request and emits it over an 8-bit valid/ready byte stream toward the chip output pins. It can emit either the absolute count or the modular difference from the previous snapshot, for drift tracking. Each frame is one header byte followed by the count bytes, least-significant byte first.

## Interface
Parameters:
- `LENGTH`, 20: width of `cycle_count`; must match the measurement stage (≥ 8).

Ports:
- `clk`  in  1  single clock, same domain as the measurement counter.
- `reset`  in  1  synchronous, active-high reset.
- `cycle_count`  in  LENGTH  latched count from the measurement stage; stable between latches.
- `start`  in  1  level-sampled request to capture and send one frame.
- `delta_mode`  in  1  sampled with `start`: 0 = absolute, 1 = difference from previous snapshot.
- `data_out`  out  8  current frame byte.
- `data_valid`  out  1  `data_out` is valid.
- `data_ready`  in  1  sink accepts the byte when it is high together with `data_valid`.
- `busy`  out  1  frame in progress.
- `overrun`  out  1  sticky flag: a `start` was seen while not idle.

## Operation
- NBYTES = ceil(LENGTH/8); frame length = 1 + NBYTES (4 for LENGTH=20).
- States are IDLE and SEND.
- IDLE, on `start`=1:
  - snapshot = `delta_mode` ? (`cycle_count` − prev) mod 2^LENGTH : `cycle_count`.
  - prev <= `cycle_count`; the raw count is always stored, in both modes.
  - header <= {4'hA, `delta_mode`, seq[2:0]}.
  - seq <= seq + 1, wrapping 7 -> 0.
  - idx <= 0; go to SEND.
- SEND:
  - idx 0 drives the header.
  - idx k (1..NBYTES) drives snapshot[8k−1 : 8k−8]; bits at or above LENGTH read as 0.
  - On a transfer (`data_valid` & `data_ready`): idx increments.
  - The transfer at idx = NBYTES returns the block to IDLE.
- `start` while in SEND: ignored and sets `overrun`. Only `reset` clears `overrun`.
- `delta_mode` and `cycle_count` changes during SEND do not affect the frame in flight.
- `busy` = (state == SEND); `data_valid` = `busy`.
- `data_out` = 0 in IDLE.
- Reset values:
  - `data_out`=0, `data_valid`=0, `busy`=0, `overrun`=0.
  - prev=0, seq=0, state IDLE.
  - The first delta after reset therefore equals `cycle_count`.
- `reset` in mid-frame aborts the frame on the next edge. No partial-frame completion; prev and seq return to 0.

## Timing
- `start` high at edge N (state IDLE) -> `data_valid`=1 with the header from cycle N+1 (1-cycle latency).
- `data_out` is registered and held stable while `data_valid` & !`data_ready`. Sink stalls of any length are allowed.
- With `data_ready` held at 1, one byte transfers per cycle: a full frame occupies exactly 1+NBYTES cycles of `busy`.
- Final transfer at edge M -> `data_valid`=0 and `busy`=0 from cycle M+1.
  - A `start` sampled at edge M (the state is still SEND) is ignored and sets `overrun`.
  - The earliest accepted restart is at edge M+1; back-to-back frames therefore have a 1-cycle gap.
- `overrun` rises the cycle after the offending edge.
- `start` held high continuously: a new frame begins each time the block re-enters IDLE. `overrun` is also set for every SEND cycle in which `start` is high.
- Delta subtraction is LENGTH-bit modular; no borrow or sign output.

## Test plan
- Reset, `cycle_count`=0x12345, `start` pulse with `delta_mode`=0, `data_ready`=1 -> bytes 0xA0, 0x45, 0x23, 0x01 on consecutive cycles; `busy` high for 4 cycles.
- Then `cycle_count`=0x12400, `start` with `delta_mode`=1 -> 0xA9, 0xBB, 0x00, 0x00.
- Wrap case: prev=0xFFFF0, `cycle_count`=0x00010, delta mode -> count bytes 0x20, 0x00, 0x00. Eight consecutive frames -> header seq field runs 0..7 then back to 0.
- Backpressure: `data_ready` toggles 0,0,1,0,1,... -> each byte is held unchanged until accepted; no byte is lost or duplicated; total cycles = stalls + 4.
- `start` during SEND and at the final-transfer edge -> frame content is unchanged, no new frame starts, `overrun`=1 until `reset`.
- `reset` asserted during byte 2 -> next cycle `data_valid`=0, `busy`=0, `overrun`=0. The next delta-mode frame's count bytes equal the absolute `cycle_count` and its header is 0xA8.

Source files
------------

// File: rtl/count_readout.sv
// count_readout: snapshots the latched cycle count on request and streams it
// out as one header byte plus ceil(LENGTH/8) count bytes, LSB first, over an
// 8-bit valid/ready interface. Optional delta mode sends the modular
// difference from the previous snapshot instead of the absolute count.
module count_readout #(
  parameter int LENGTH = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] cycle_count,
  input  logic              start,
  input  logic              delta_mode,
  output logic [7:0]        data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              overrun
);

  localparam int NBYTES = (LENGTH + 7) / 8;
  localparam int SW     = NBYTES * 8;
  localparam int IDXW   = $clog2(NBYTES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [SW-1:0]     snapshot;
  logic [LENGTH-1:0] prev;
  logic [2:0]        seq;

  logic [LENGTH-1:0] diff;
  logic [SW-1:0]     snap_next;
  logic [7:0]        header_next;
  logic [SW-1:0]     shifted;
  logic [7:0]        next_byte;
  logic              last_byte;

  // Next-frame snapshot/header and the byte that follows the current index.
  always_comb begin
    diff        = cycle_count - prev;
    snap_next   = '0;
    if (delta_mode) begin
      snap_next[LENGTH-1:0] = diff;
    end else begin
      snap_next[LENGTH-1:0] = cycle_count;
    end
    header_next = {4'hA, delta_mode, seq};
    // Byte k (k = idx + 1) lives at bit offset 8*idx of the snapshot.
    shifted     = snapshot >> {idx, 3'b000};
    next_byte   = shifted[7:0];
    last_byte   = (idx == IDXW'(NBYTES));
  end

  // Frame FSM with registered stream outputs and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      snapshot   <= '0;
      prev       <= '0;
      seq        <= 3'd0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            snapshot   <= snap_next;
            prev       <= cycle_count;
            seq        <= seq + 3'd1;
            idx        <= '0;
            data_out   <= header_next;
            data_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= SEND;
          end else begin
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        SEND: begin
          if (start) begin
            overrun <= 1'b1;
          end else begin
            overrun <= overrun;
          end
          // data_valid is always high in SEND, so ready alone marks a transfer.
          if (data_ready) begin
            if (last_byte) begin
              data_out   <= 8'h00;
              data_valid <= 1'b0;
              busy       <= 1'b0;
              idx        <= '0;
              state      <= IDLE;
            end else begin
              data_out <= next_byte;
              idx      <= idx + IDXW'(1);
            end
          end else begin
            data_out <= data_out;
          end
        end
        default: begin
          state      <= IDLE;
          data_out   <= 8'h00;
          data_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_readout.sv
// Self-checking bench for count_readout (LENGTH=20): a byte scoreboard fed by
// a reference model when frames are requested, checked as bytes transfer.
module tb_count_readout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cycle_count = 20'h0;
  logic        start = 1'b0;
  logic        delta_mode = 1'b0;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready = 1'b1;
  logic        busy;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_q[$];
  logic [19:0] m_prev = 20'h0;
  logic [2:0]  m_seq = 3'd0;

  logic        prev_stalled = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  count_readout #(.LENGTH(20)) dut (
    .clk         (clk),
    .reset       (reset),
    .cycle_count (cycle_count),
    .start       (start),
    .delta_mode  (delta_mode),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop and compare every accepted byte; check stalled bytes hold.
  always @(negedge clk) begin
    if (prev_stalled && data_valid && !reset) begin
      n_cmp++;
      if (data_out !== prev_byte) begin
        n_err++;
        $display("FAIL hold: data_out=%h required=%h", data_out, prev_byte);
      end
    end
    if (data_valid && data_ready && !reset) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte: data_out=%h required=no transfer", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_err++;
          $display("FAIL byte: data_out=%h required=%h", data_out, e);
        end
      end
    end
    prev_stalled = data_valid && !data_ready && !reset;
    prev_byte    = data_out;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a frame for one cycle and push its expected bytes.
  task automatic start_frame(input logic [19:0] cc, input logic dm);
    logic [19:0] snap;
    snap = dm ? (cc - m_prev) : cc;
    exp_q.push_back({4'hA, dm, m_seq});
    exp_q.push_back(snap[7:0]);
    exp_q.push_back(snap[15:8]);
    exp_q.push_back({4'h0, snap[19:16]});
    m_prev = cc;
    m_seq  = m_seq + 3'd1;
    cycle_count = cc;
    delta_mode  = dm;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      step();
    end
    if (cyc >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: busy still %b after %0d cycles", busy, cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++; if (data_out !== 8'h00) begin n_err++; $display("FAIL rst_data: %h vs 00", data_out); end
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: %b vs 0", data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: %b vs 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: %b vs 0", overrun); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_absolute();
    int cyc;
    data_ready = 1'b1;
    start_frame(20'h12345, 1'b0);
    n_cmp++; if (data_out !== 8'hA0 || data_valid !== 1'b1) begin n_err++; $display("FAIL abs_header: %h/%b vs A0/1", data_out, data_valid); end
    wait_idle(cyc);
    n_cmp++; if (cyc != 4) begin n_err++; $display("FAIL abs_busy_cycles: %0d vs 4", cyc); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL abs_drain: %0d left vs 0", exp_q.size()); end
  endtask

  task automatic test_delta();
    int cyc;
    start_frame(20'h12400, 1'b1);
    n_cmp++; if (data_out !== 8'hA9) begin n_err++; $display("FAIL delta_header: %h vs A9", data_out); end
    step();
    n_cmp++; if (data_out !== 8'hBB) begin n_err++; $display("FAIL delta_byte1: %h vs BB", data_out); end
    wait_idle(cyc);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL delta_drain: %0d left vs 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    int cyc;
    start_frame(20'hFFFF0, 1'b0);
    wait_idle(cyc);
    step();
    start_frame(20'h00010, 1'b1);
    step();
    n_cmp++; if (data_out !== 8'h20) begin n_err++; $display("FAIL wrap_byte1: %h vs 20", data_out); end
    wait_idle(cyc);
    // Eight more frames: header seq field walks through every value and wraps.
    for (int i = 0; i < 8; i++) begin
      step();
      start_frame(20'h0ABCD + 20'(i * 333), i[0]);
      wait_idle(cyc);
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_drain: %0d left vs 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int cyc = 0;
    int stalls = 0;
    data_ready = 1'b0;
    start_frame(20'h9C3E7, 1'b0);
    for (int i = 0; i < 60 && busy === 1'b1; i++) begin
      data_ready = (i < 2) ? 1'b0 : (((i - 2) % 2) == 0);
      cyc++;
      if (!data_ready) stalls++;
      step();
    end
    data_ready = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_timeout: busy=%b vs 0", busy); end
    n_cmp++; if (cyc != stalls + 4) begin n_err++; $display("FAIL bp_cycles: %0d vs %0d", cyc, stalls + 4); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_drain: %0d left vs 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    data_ready = 1'b1;
    step();
    start_frame(20'h01234, 1'b0);  // now in header cycle
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pre: %b vs 0", overrun); end
    start = 1'b1;                    // seen during SEND
    step();
    start = 1'b0;
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: %b vs 1", overrun); end
    step();
    step();                          // last byte cycle
    start = 1'b1;                    // sampled at the final-transfer edge
    step();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0 || data_valid !== 1'b0) begin n_err++; $display("FAIL ovr_no_restart: busy=%b valid=%b vs 0/0", busy, data_valid); end
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_idle: busy=%b vs 0", busy); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: %b vs 1", overrun); end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ovr_drain: %0d left vs 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_frame(20'h0F0F0, 1'b1);
    step();
    step();                          // byte 2 on the bus
    reset = 1'b1;
    step();
    n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: %b vs 0", data_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: %b vs 0", busy); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rmid_overrun: %b vs 0", overrun); end
    reset = 1'b0;
    exp_q.delete();
    m_prev = 20'h0;
    m_seq  = 3'd0;
    step();
    start_frame(20'h54321, 1'b1);
    n_cmp++; if (data_out !== 8'hA8) begin n_err++; $display("FAIL rmid_header: %h vs A8", data_out); end
    step();
    n_cmp++; if (data_out !== 8'h21) begin n_err++; $display("FAIL rmid_byte1: %h vs 21", data_out); end
    wait_idle(cyc);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rmid_drain: %0d left vs 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_absolute();
    test_delta();
    test_wrap();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "timeout");
  end

endmodule
